// File: rtl/mem_word_master.sv
// mem_word_master: splits one 32-bit CPU load/store into two 16-bit memory
// accesses, low half at base and high half at base+1 (little-endian).
// Define MEM_ALIGN_CHECK_EN to reject odd base addresses: the access then
// completes at once with err=1 and no memory strobes.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req, we, addr, wdata      request from the datapath (sampled in IDLE)
//   busy, done, rdata, err    status and assembled load word to the datapath
//   mem_read, mem_write,
//   address, write_data       halfword memory interface (all registered)
//   read_data                 combinational memory read data
module mem_word_master #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*HALF_W-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic [2*HALF_W-1:0] rdata,
  output logic                err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   address,
  output logic [HALF_W-1:0]   write_data,
  input  logic [HALF_W-1:0]   read_data
);

  localparam int unsigned WORD_W = 2 * HALF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [HALF_W-1:0]   write_data_q, write_data_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                misaligned_c;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_c = addr[0];
`else
  assign misaligned_c = 1'b0;
`endif

  // Next state plus next value of every output; outputs are the flopped
  // decode of the state being entered, so they line up with the state.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    address_d    = address_q;
    write_data_d = write_data_q;
    rdata_d      = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          base_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (misaligned_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d      = S_LO;
            address_d    = addr;
            mem_read_d   = ~we;
            mem_write_d  = we;
            write_data_d = wdata[HALF_W-1:0];
          end
        end
      end
      S_LO: begin
        state_d      = S_HI;
        busy_d       = 1'b1;
        mem_read_d   = ~we_q;
        mem_write_d  = we_q;
        // base+1 wraps at the top of the halfword space
        address_d    = base_q + ADDR_W'(1);
        write_data_d = wdata_q[WORD_W-1:HALF_W];
        if (!we_q) rdata_d[HALF_W-1:0] = read_data;
      end
      S_HI: begin
        state_d = S_DONE;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        if (!we_q) rdata_d[WORD_W-1:HALF_W] = read_data;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      rdata_q      <= rdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign address    = address_q;
  assign write_data = write_data_q;

endmodule
